// File: rtl/m_eventually_mon.sv
// Multi-channel req -> ack -> done handshake monitor: tracks one transaction per channel,
// reports ack latency and flags timeout, overlap and end-of-sim pending violations.
module m_eventually_mon #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNTW     = 8,
  parameter int unsigned MAX_ACK  = 0,
  parameter int unsigned MAX_DONE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      req,
  input  logic [NCH-1:0]      ack,
  input  logic [NCH-1:0]      done,
  input  logic                eos,
  output logic [NCH-1:0]      busy,
  output logic [NCH*CNTW-1:0] ack_lat,
  output logic [NCH-1:0]      ack_vld,
  output logic [NCH-1:0]      done_ok,
  output logic [NCH-1:0]      ack_to,
  output logic [NCH-1:0]      done_to,
  output logic [NCH-1:0]      ovl_err,
  output logic [NCH-1:0]      pend_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WACK  = 2'd1;
  localparam logic [1:0] S_WDONE = 2'd2;

  localparam logic [CNTW-1:0] CNT_SAT  = '1;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] ACK_LIM  = CNTW'(MAX_ACK);
  localparam logic [CNTW-1:0] DONE_LIM = CNTW'(MAX_DONE);
  localparam logic            ACK_BND  = (MAX_ACK != 0);
  localparam logic            DONE_BND = (MAX_DONE != 0);

  logic [NCH-1:0] req_q;

  // Request history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= req;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]      state, state_nx;
    logic [CNTW-1:0] cnt, cnt_nx, cnt_inc;
    logic [CNTW-1:0] lat, lat_nx;
    logic            vld_q, vld_nx, ok_q, ok_nx;
    logic            ato_q, ato_nx, dto_q, dto_nx;
    logic            ovl_q, ovl_nx, pend_q, pend_nx;
    logic            start, in_txn;

    assign start   = req[i] & ~req_q[i];
    assign in_txn  = (state != S_IDLE);
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt_inc;
      lat_nx   = lat;
      vld_nx   = 1'b0;
      ok_nx    = 1'b0;
      ato_nx   = ato_q;
      dto_nx   = dto_q;
      ovl_nx   = ovl_q | (start & in_txn);
      case (state)
        S_IDLE: begin
          cnt_nx = '0;
          if (start) begin
            state_nx = S_WACK;
            cnt_nx   = CNT_ONE;
          end
        end
        S_WACK: begin
          if (ack[i]) begin
            lat_nx = cnt;
            vld_nx = 1'b1;
            if (done[i]) begin
              ok_nx    = 1'b1;
              state_nx = S_IDLE;
              cnt_nx   = '0;
            end else begin
              state_nx = S_WDONE;
              cnt_nx   = CNT_ONE;
            end
          end else if (ACK_BND && cnt == ACK_LIM) begin
            ato_nx   = 1'b1;
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end
        end
        S_WDONE: begin
          if (done[i]) begin
            ok_nx    = 1'b1;
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (DONE_BND && cnt == DONE_LIM) begin
            dto_nx   = 1'b1;
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
      // A completion in the eos cycle is not a pending transaction.
      pend_nx = pend_q | (eos & in_txn & ~ok_nx);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= S_IDLE;
        cnt    <= '0;
        lat    <= '0;
        vld_q  <= 1'b0;
        ok_q   <= 1'b0;
        ato_q  <= 1'b0;
        dto_q  <= 1'b0;
        ovl_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        state  <= state_nx;
        cnt    <= cnt_nx;
        lat    <= lat_nx;
        vld_q  <= vld_nx;
        ok_q   <= ok_nx;
        ato_q  <= ato_nx;
        dto_q  <= dto_nx;
        ovl_q  <= ovl_nx;
        pend_q <= pend_nx;
      end
    end

    assign busy[i]                 = in_txn;
    assign ack_lat[i*CNTW +: CNTW] = lat;
    assign ack_vld[i]              = vld_q;
    assign done_ok[i]              = ok_q;
    assign ack_to[i]               = ato_q;
    assign done_to[i]              = dto_q;
    assign ovl_err[i]              = ovl_q;
    assign pend_err[i]             = pend_q;
  end

endmodule

// File: tb/tb_m_eventually_mon.sv
// Directed bench for m_eventually_mon: an unbounded instance (u0) and a MAX_ACK/MAX_DONE=3 instance (u1).
module tb_m_eventually_mon;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CNTW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  req, ack, done;
  logic            eos;

  logic [NCH-1:0]      busy0, vld0, ok0, ato0, dto0, ovl0, pend0;
  logic [NCH*CNTW-1:0] lat0;
  logic [NCH-1:0]      busy1, vld1, ok1, ato1, dto1, ovl1, pend1;
  logic [NCH*CNTW-1:0] lat1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_eventually_mon #(.NCH(NCH), .CNTW(CNTW), .MAX_ACK(0), .MAX_DONE(0)) u0 (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .done(done), .eos(eos),
    .busy(busy0), .ack_lat(lat0), .ack_vld(vld0), .done_ok(ok0),
    .ack_to(ato0), .done_to(dto0), .ovl_err(ovl0), .pend_err(pend0)
  );

  m_eventually_mon #(.NCH(NCH), .CNTW(CNTW), .MAX_ACK(3), .MAX_DONE(3)) u1 (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .done(done), .eos(eos),
    .busy(busy1), .ack_lat(lat1), .ack_vld(vld1), .done_ok(ok1),
    .ack_to(ato1), .done_to(dto1), .ovl_err(ovl1), .pend_err(pend1)
  );

  typedef struct {
    logic       rst, req, ack, done;
    logic       busy, vld, ok, ovl;
    logic [7:0] lat;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic q, input logic a, input logic d,
                     input logic b, input logic v, input logic o, input logic ov,
                     input logic [7:0] l);
    vec_t t;
    t.rst = r; t.req = q; t.ack = a; t.done = d;
    t.busy = b; t.vld = v; t.ok = o; t.ovl = ov; t.lat = l;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] a,
                       input logic [3:0] d, input logic e);
    rst = r; req = q; ack = a; done = d; eos = e;
    step();
  endtask

  initial begin
    rst = 1'b1; req = '0; ack = '0; done = '0; eos = 1'b0;
    step();

    // rst req ack done | busy vld ok ovl lat   (channel 0 of u0)
    add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    add(1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
    add(1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd3);

    foreach (tv[k]) begin
      drive(tv[k].rst, {3'b000, tv[k].req}, {3'b000, tv[k].ack}, {3'b000, tv[k].done}, 1'b0);
      chk($sformatf("v%0d busy", k), 32'(busy0), {28'd0, 3'b000, tv[k].busy});
      chk($sformatf("v%0d ack_vld", k), 32'(vld0), {28'd0, 3'b000, tv[k].vld});
      chk($sformatf("v%0d done_ok", k), 32'(ok0), {28'd0, 3'b000, tv[k].ok});
      chk($sformatf("v%0d ovl_err", k), 32'(ovl0), {28'd0, 3'b000, tv[k].ovl});
      chk($sformatf("v%0d ack_lat", k), lat0, {24'd0, tv[k].lat});
      chk($sformatf("v%0d to/pend", k), {16'd0, ato0, dto0, pend0, 4'h0}, 32'd0);
    end

    // Ack timeout on u1: ack never arrives, flag sticky, late ack ignored
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("rst u1 busy", 32'(busy1), 32'd0);
    chk("rst u1 ack_to", 32'(ato1), 32'd0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    chk("ato pre busy", 32'(busy1), 32'h1);
    chk("ato pre flag", 32'(ato1), 32'h0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    chk("ato busy", 32'(busy1), 32'h0);
    chk("ato flag", 32'(ato1), 32'h1);
    drive(1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
    chk("late ack vld", 32'(vld1), 32'h0);
    chk("ato sticky", 32'(ato1), 32'h1);

    // Ack exactly at the bound is legal; then done timeout
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h1, 4'h1, 4'h0, 1'b0);
    chk("bnd ack vld", 32'(vld1), 32'h1);
    chk("bnd ack lat", lat1, 32'd3);
    chk("bnd ack_to", 32'(ato1), 32'h0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    chk("dto pre", {busy1, dto1}, {4'h1, 4'h0});
    drive(1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    chk("dto busy/flag", {busy1, dto1}, {4'h0, 4'h1});

    // Multi-channel eos: ch0 completes, ch2 still waiting on done
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h5, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h5, 4'h5, 4'h1, 1'b0);
    chk("mc done_ok", 32'(ok0), 32'h1);
    chk("mc ack_vld", 32'(vld0), 32'h5);
    chk("mc ack_lat", lat0, 32'h0001_0001);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("mc pend_err", 32'(pend0), 32'h4);
    chk("mc busy", 32'(busy0), 32'h4);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("mc rst clear", {busy0, vld0, ok0, ato0, dto0, ovl0, pend0}, 28'd0);
    chk("mc rst lat", lat0, 32'd0);

    // Completion in the eos cycle wins over pending
    drive(1'b0, 4'h2, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h2, 4'h2, 4'h2, 1'b1);
    chk("eos compl ok", 32'(ok0), 32'h2);
    chk("eos compl pend", 32'(pend0), 32'h0);

    // Reset mid-transaction aborts silently
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h8, 4'h0, 4'h0, 1'b0);
    chk("abort pre busy", 32'(busy0), 32'h8);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("abort busy/err", {busy0, pend0, ovl0}, 12'd0);

    // Unbounded latency saturates at 255
    drive(1'b0, 4'h8, 4'h0, 4'h0, 1'b0);
    for (int n = 0; n < 300; n++) drive(1'b0, 4'h8, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h8, 4'h8, 4'h0, 1'b0);
    chk("sat vld", 32'(vld0), 32'h8);
    chk("sat lat", lat0, 32'hFF00_0000);
    chk("sat errs", {ato0, dto0, ovl0, pend0}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
